// File: rtl/mdu_pkg.sv
// Shared definitions for the pipelined multiply/divide unit: op encodings,
// sequencer states and the default iteration count.
`timescale 1ns/1ps
package mdu_pkg;

    localparam int MDU_ITER = 32;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step. rem_i is the previous remainder shifted left
// with the next dividend bit appended; it is always below 2*dvsr_i, so the
// borrow of the trial subtraction alone decides the quotient bit.
`timescale 1ns/1ps
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] diff;

    // Trial subtract; keep the difference when no borrow, else restore.
    always_comb begin
        diff  = rem_i - {1'b0, dvsr_i};
        q_o   = ~diff[WIDTH];
        rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
    end

endmodule

// File: rtl/pipe_mdu.sv
// Iterative MIPS-style multiply/divide unit for the EXE stage.
// Shift-add multiply and restoring divide on operand magnitudes, one
// iteration per clock, signs applied in a final fix-up cycle.
// Optional build macro MDU_EARLY_OUT_EN: a multiply stops iterating once the
// remaining multiplier bits are all zero (results are unchanged).
`timescale 1ns/1ps
module pipe_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;      // current op is a divide
    logic               divz_q;     // divide by zero: acc_q already holds {a, ones}
    logic               negq_q;     // negate product / quotient
    logic               negr_q;     // negate remainder
    logic [2*WIDTH-1:0] acc_q;      // mult: product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand_q;    // mult: shifting multiplicand; div: divisor in low half
    logic [WIDTH-1:0]   mplier_q;   // mult: remaining multiplier bits
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic             op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    logic [WIDTH:0]   div_part_d;
    logic [WIDTH-1:0] div_rem_d;
    logic             div_qbit_d;

    assign div_part_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i  (div_part_d),
        .dvsr_i (mcand_q[WIDTH-1:0]),
        .rem_o  (div_rem_d),
        .q_o    (div_qbit_d)
    );

    logic [2*WIDTH-1:0] acc_d;

    // Accumulator after one iteration of whichever operation is running.
    always_comb begin
        if (div_q) begin
            acc_d = {div_rem_d, acc_q[WIDTH-2:0], div_qbit_d};
        end else begin
            acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        end
    end

    logic early_exit;
`ifdef MDU_EARLY_OUT_EN
    assign early_exit = ~div_q & (mplier_q == '0);
`else
    assign early_exit = 1'b0;
`endif

    logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;
    logic [2*WIDTH-1:0] acc_neg;

    // Sign fix-up of the magnitude result, or the divide-by-zero pattern.
    always_comb begin
        acc_neg  = -acc_q;
        fix_hi_d = acc_q[2*WIDTH-1:WIDTH];
        fix_lo_d = acc_q[WIDTH-1:0];
        if (divz_q) begin
            fix_hi_d = acc_q[2*WIDTH-1:WIDTH];
            fix_lo_d = acc_q[WIDTH-1:0];
        end else if (!div_q) begin
            if (negq_q) begin
                fix_hi_d = acc_neg[2*WIDTH-1:WIDTH];
                fix_lo_d = acc_neg[WIDTH-1:0];
            end
        end else begin
            if (negq_q) fix_lo_d = -acc_q[WIDTH-1:0];
            if (negr_q) fix_hi_d = -acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer: IDLE -> RUN (WIDTH iterations) -> FIX -> DONE -> IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            divz_q   <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        div_q  <= op_div;
                        negq_q <= a_neg ^ b_neg;
                        negr_q <= a_neg;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (op_div && (b == '0)) begin
                            divz_q  <= 1'b1;
                            acc_q   <= {a, {WIDTH{1'b1}}};
                            state_q <= FIX;
                        end else begin
                            divz_q   <= 1'b0;
                            acc_q    <= op_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                            mcand_q  <= {{WIDTH{1'b0}}, op_div ? b_mag : a_mag};
                            mplier_q <= b_mag;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (early_exit) begin
                        state_q <= FIX;
                    end else begin
                        acc_q <= acc_d;
                        if (!div_q) begin
                            mcand_q  <= mcand_q << 1;
                            mplier_q <= mplier_q >> 1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall = ((state_q == IDLE) & start & ~flush) | (state_q == RUN) | (state_q == FIX);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: directed vectors with hand-computed results
// are queued at issue time; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_pipe_mdu;
    import mdu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    pipe_mdu #(.WIDTH(32), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    logic [32:0] st_rem_i = '0;
    logic [31:0] st_dvsr  = 32'd1;
    logic [31:0] st_rem_o;
    logic        st_q;

    mdu_div_step #(.WIDTH(32)) u_ref_step (
        .rem_i  (st_rem_i),
        .dvsr_i (st_dvsr),
        .rem_o  (st_rem_o),
        .q_o    (st_q)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected edge count from start sample to the done cycle for a multiply.
    function automatic int mlat(input logic [31:0] m);
`ifdef MDU_EARLY_OUT_EN
        int k = -1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return k + 4;
`else
        return 34;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_hi"}, hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, lo, mon_e.lo);
                $display("%s: hi=%h lo=%h (expected hi=%h lo=%h)", mon_e.name, hi, lo, mon_e.hi, mon_e.lo);
            end
        end
    end

    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                         input int lat);
        exp_t e;
        int   edges;
        int   stall_cnt;
        @(negedge clock);
        op = o; a = av; b = bv; start = 1'b1;
        e.hi = eh; e.lo = el; e.name = nm;
        sb_q.push_back(e);
        #1;
        chk({nm, "_stall_req"}, 32'(stall), 32'd1);
        @(posedge clock); #1;
        start = 1'b0;
        edges = 1;
        stall_cnt = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (stall === 1'b1) stall_cnt++;
            @(posedge clock); #1;
            edges++;
        end
        chk({nm, "_latency"}, 32'(edges), 32'(lat));
        chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(lat - 1));
        chk({nm, "_stall_in_done"}, 32'(stall), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Divide step used by the reference side
        st_rem_i = 33'd13; st_dvsr = 32'd7; #1;
        chk("step_13_7_rem", st_rem_o, 32'd6);
        chk("step_13_7_q", 32'(st_q), 32'd1);
        st_rem_i = 33'd5; #1;
        chk("step_5_7_q", 32'(st_q), 32'd0);
        st_rem_i = 33'h1_0000_0000; st_dvsr = 32'h8000_0001; #1;
        chk("step_carry_rem", st_rem_o, 32'h7FFF_FFFF);

        issue("mult_m1x2",   MDU_MULT,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, mlat(32'd2));
        issue("multu_maxx2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, mlat(32'd2));
        issue("mult_m3xm5",  MDU_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0,        32'd15,        mlat(32'd5));
        issue("multu_shift", MDU_MULTU, 32'h1234_5678, 32'h10,       32'h1,         32'h2345_6780, mlat(32'h10));
        issue("div_m7_2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        issue("div_7_m2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 34);
        issue("divu_100_7",  MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        34);
        issue("divu_max_10", MDU_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999, 34);
        issue("divu_5_0",    MDU_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 2);
        issue("div_m8_0",    MDU_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, 2);
        issue("div_min_m1",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 34);

        // Flush at iteration 10; the high multiplier bit keeps the op running in either build.
        @(negedge clock);
        op = MDU_MULTU; a = 32'd3; b = 32'h4000_0004; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_hi_kept", hi, 32'h0);
        chk("flush_lo_kept", lo, 32'h8000_0000);
        repeat (40) @(posedge clock);
        #1;
        chk("flush_still_idle", 32'(busy), 32'd0);
        $display("flush_multu: aborted, hi=%h lo=%h", hi, lo);

        issue("div_7_m2_again", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);

        // Reset at iteration 5 clears hi/lo at once.
        @(negedge clock);
        op = MDU_MULT; a = 32'd5; b = 32'h4000_0006; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset_hi", hi, 32'h0);
        chk("midreset_lo", lo, 32'h0);
        chk("midreset_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        $display("midreset_mult: hi=%h lo=%h", hi, lo);

        issue("multu_9x1",   MDU_MULTU, 32'd9,         32'd1, 32'h0, 32'd9, mlat(32'd1));
        issue("mult_m1x0",   MDU_MULT,  32'hFFFF_FFFF, 32'd0, 32'h0, 32'h0, mlat(32'd0));

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mdu.md
Name: pipe_mdu

Overview:
- Iterative multiply/divide unit in the EXE stage of the five-stage pipelined computer.
- Sits directly upstream of the memory stage. Its HI/LO results feed the EXE result mux, then the EXE/MEM register, then the memory stage's address/data path (e.g. a product used as a store address or as store data).
- Holds the pipeline through a stall output while an operation runs.
- Handles signed and unsigned multiply and divide, MIPS semantics (mult, multu, div, divu).

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  EXE holds an MDU instruction; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  EXE instruction squashed (branch/jump); aborts the operation.
- stall  out  1  freeze PC, IF/ID and ID/EXE.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: hi/lo were just updated.
- hi  out  WIDTH  product high word / remainder.
- lo  out  WIDTH  product low word / quotient.

Behaviour:
- Interface fixed: one clock `clock`; `reset` is asynchronous and active-high.
- Reset values: state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0.
- States:
  - IDLE: start=1 and flush=0 at an edge latches |a|, |b|, sign bits and op, clears the partial result, sets counter=0, goes to RUN.
  - RUN: one iteration per cycle; after iteration WIDTH-1 goes to FIX.
  - FIX: applies signs and writes hi/lo, goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: start sampled at edge N → hi/lo valid and done=1 in the cycle after edge N+WIDTH+1 (34 cycles at WIDTH=32).
- stall = (state==IDLE & start & ~flush) | (state==RUN) | (state==FIX). stall=0 in DONE, so EXE advances that cycle with the final hi/lo.
- busy = 1 in RUN and FIX.
- Multiply: shift-add on magnitudes, 2*WIDTH-bit accumulator.
  - Signed: negate the 64-bit result if sign(a) xor sign(b).
  - Unsigned: no sign handling.
- Divide: restoring, one quotient bit per iteration.
  - Signed: quotient negated if sign(a) xor sign(b); remainder takes the sign of a.
  - -2^31 / -1 yields lo=0x80000000, hi=0 (no trap).
- Divide by zero: detected in IDLE. Goes straight to FIX (one cycle of stall); lo=all ones, hi=a, regardless of signedness.
- start while busy is ignored. start in DONE is ignored; it is sampled again in the following IDLE cycle.
- flush in RUN or FIX: next state IDLE, hi/lo unchanged, no done pulse. flush in IDLE overrides start.
- Reset mid-operation: immediate return to IDLE, hi/lo cleared.
- hi/lo hold their value between operations.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: a multiply leaves RUN for FIX as soon as the remaining multiplier bits are all zero. The check is made after each iteration and before the first iteration, so b=0 takes 0 iterations and latency varies with b. Divide latency is unchanged.
- Undefined: every multiply and divide takes exactly WIDTH iterations.
- hi/lo results are identical in both builds.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state enum IDLE, RUN, FIX, DONE;
  - constant MDU_ITER = 32.
- One sub-module, mdu_div_step: combinational restoring-divide step (remainder, divisor → new remainder, quotient bit). It is reused by the bench's reference model.

Test Plan:
- mult a=0xFFFFFFFF, b=2 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once; stall high 33 cycles.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=100, b=7 → lo=14, hi=2.
- divu a=5, b=0 → lo=0xFFFFFFFF, hi=5, done in the third cycle after start; div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Start multu 3×4, assert flush at iteration 10 → IDLE next cycle, stall drops, hi/lo keep previous values, no done. Assert reset at iteration 5 → hi=lo=0 immediately.
- With MDU_EARLY_OUT_EN, multu a=9, b=1 → done 4 cycles after start, lo=9. Without the macro: same result at 34 cycles.
